// File: rtl/collision_scan_engine.sv
// Time-multiplexed AABB collision engine: scans every entity/obstacle pair
// once per frame edge, one pair per sysClk, and publishes results atomically.
module collision_scan_engine #(
    parameter int NUM_ENT = 4,
    parameter int NUM_OBS = 8,
    parameter int COORD_W = 10,
    parameter int RAD_W   = 8,
    parameter int IDX_W   = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1
) (
    input  logic                       sysClk,
    input  logic                       reset_n,
    input  logic                       frameClk,
    input  logic [NUM_ENT*COORD_W-1:0] entPosX,
    input  logic [NUM_ENT*COORD_W-1:0] entPosY,
    input  logic [NUM_ENT*RAD_W-1:0]   entRadX,
    input  logic [NUM_ENT*RAD_W-1:0]   entRadY,
    input  logic [NUM_ENT-1:0]         entValid,
    input  logic [NUM_OBS*COORD_W-1:0] obsPosX,
    input  logic [NUM_OBS*COORD_W-1:0] obsPosY,
    input  logic [NUM_OBS*RAD_W-1:0]   obsRadX,
    input  logic [NUM_OBS*RAD_W-1:0]   obsRadY,
    input  logic [NUM_OBS-1:0]         obsValid,
    output logic [NUM_ENT-1:0]         collide,
    output logic [NUM_ENT*IDX_W-1:0]   hitIndex,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam int ENT_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
    localparam int CMP_W = ((COORD_W > RAD_W) ? COORD_W : RAD_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                     r_frame_q;
    logic [ENT_W-1:0]         r_ent;
    logic [IDX_W-1:0]         r_obs;
    logic [NUM_ENT-1:0]       r_sh_col;
    logic [NUM_ENT*IDX_W-1:0] r_sh_idx;
    logic [NUM_ENT-1:0]       r_collide;
    logic [NUM_ENT*IDX_W-1:0] r_hit;
    logic                     r_done;
    logic                     r_overrun;

    logic                     w_start;
    logic                     w_last_obs;
    logic                     w_last_pair;
    logic                     w_busy;
    logic [COORD_W-1:0]       w_ax, w_ay, w_bx, w_by;
    logic [RAD_W-1:0]         w_arx, w_ary, w_brx, w_bry;
    logic signed [COORD_W:0]  w_dx, w_dy;
    logic [COORD_W:0]         w_adx, w_ady;
    logic [RAD_W:0]           w_sx, w_sy;
    logic                     w_hit;
    logic [NUM_ENT-1:0]       w_sh_col_nxt;
    logic [NUM_ENT*IDX_W-1:0] w_sh_idx_nxt;

    assign w_start     = frameClk & ~r_frame_q;
    assign w_last_obs  = (r_obs == IDX_W'(NUM_OBS - 1));
    assign w_last_pair = w_last_obs & (r_ent == ENT_W'(NUM_ENT - 1));

    always_ff @(posedge sysClk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        unique case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_SCAN;
            S_SCAN: begin
                w_busy = 1'b1;
                if (w_last_pair) w_state_nxt = S_COMMIT;
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Operands of the pair under evaluation this cycle
    always_comb begin
        w_ax  = entPosX[r_ent*COORD_W +: COORD_W];
        w_ay  = entPosY[r_ent*COORD_W +: COORD_W];
        w_arx = entRadX[r_ent*RAD_W +: RAD_W];
        w_ary = entRadY[r_ent*RAD_W +: RAD_W];
        w_bx  = obsPosX[r_obs*COORD_W +: COORD_W];
        w_by  = obsPosY[r_obs*COORD_W +: COORD_W];
        w_brx = obsRadX[r_obs*RAD_W +: RAD_W];
        w_bry = obsRadY[r_obs*RAD_W +: RAD_W];
    end

    always_comb begin
        w_dx  = $signed({1'b0, w_ax}) - $signed({1'b0, w_bx});
        w_dy  = $signed({1'b0, w_ay}) - $signed({1'b0, w_by});
        w_adx = w_dx[COORD_W] ? $unsigned(-w_dx) : $unsigned(w_dx);
        w_ady = w_dy[COORD_W] ? $unsigned(-w_dy) : $unsigned(w_dy);
        w_sx  = {1'b0, w_arx} + {1'b0, w_brx};
        w_sy  = {1'b0, w_ary} + {1'b0, w_bry};
        w_hit = (CMP_W'(w_adx) < CMP_W'(w_sx))
              & (CMP_W'(w_ady) < CMP_W'(w_sy))
              & entValid[r_ent] & obsValid[r_obs];
    end

    // First hit per entity wins, so hitIndex is the lowest obstacle
    always_comb begin
        w_sh_col_nxt = r_sh_col;
        w_sh_idx_nxt = r_sh_idx;
        if ((r_state == S_SCAN) && w_hit && !r_sh_col[r_ent]) begin
            w_sh_col_nxt[r_ent]                 = 1'b1;
            w_sh_idx_nxt[r_ent*IDX_W +: IDX_W]  = r_obs;
        end
    end

    always_ff @(posedge sysClk) begin
        if (!reset_n) begin
            r_frame_q <= 1'b1;
            r_ent     <= '0;
            r_obs     <= '0;
            r_sh_col  <= '0;
            r_sh_idx  <= '0;
            r_collide <= '0;
            r_hit     <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_frame_q <= frameClk;
            r_done    <= 1'b0;
            if (w_start && (r_state != S_IDLE)) r_overrun <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_ent    <= '0;
                        r_obs    <= '0;
                        r_sh_col <= '0;
                        r_sh_idx <= '0;
                    end
                end
                S_SCAN: begin
                    r_sh_col <= w_sh_col_nxt;
                    r_sh_idx <= w_sh_idx_nxt;
                    if (w_last_obs) begin
                        r_obs <= '0;
                        r_ent <= r_ent + 1'b1;
                    end else begin
                        r_obs <= r_obs + 1'b1;
                    end
                    // Publish on the edge that enters COMMIT, last pair included
                    if (w_last_pair) begin
                        r_ent     <= '0;
                        r_collide <= w_sh_col_nxt;
                        r_hit     <= w_sh_idx_nxt;
                        r_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign collide  = r_collide;
    assign hitIndex = r_hit;
    assign busy     = w_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_collision_scan_engine.sv
// Self-checking bench for collision_scan_engine (2 entities x 4 obstacles)
// against a geometric reference model plus literal expectations.
module tb_collision_scan_engine;

    localparam int NE = 2;
    localparam int NO = 4;
    localparam int CW = 10;
    localparam int RW = 8;
    localparam int IW = 2;
    localparam int P  = NE * NO;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              frameClk;
    logic [NE*CW-1:0]  entPosX, entPosY;
    logic [NE*RW-1:0]  entRadX, entRadY;
    logic [NE-1:0]     entValid;
    logic [NO*CW-1:0]  obsPosX, obsPosY;
    logic [NO*RW-1:0]  obsRadX, obsRadY;
    logic [NO-1:0]     obsValid;
    logic [NE-1:0]     collide;
    logic [NE*IW-1:0]  hitIndex;
    logic              busy, done, overrun;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    collision_scan_engine #(
        .NUM_ENT(NE), .NUM_OBS(NO), .COORD_W(CW), .RAD_W(RW)
    ) dut (
        .sysClk(clk), .reset_n(reset_n), .frameClk(frameClk),
        .entPosX(entPosX), .entPosY(entPosY),
        .entRadX(entRadX), .entRadY(entRadY), .entValid(entValid),
        .obsPosX(obsPosX), .obsPosY(obsPosY),
        .obsRadX(obsRadX), .obsRadY(obsRadY), .obsValid(obsValid),
        .collide(collide), .hitIndex(hitIndex),
        .busy(busy), .done(done), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference: plain rectangle-overlap geometry over all valid pairs
    function automatic void model_results(output logic [NE-1:0] col,
                                          output logic [NE*IW-1:0] hit);
        col = '0;
        hit = '0;
        for (int e = 0; e < NE; e++) begin
            for (int o = 0; o < NO; o++) begin
                int dx, dy, sx, sy;
                dx = int'(entPosX[e*CW +: CW]) - int'(obsPosX[o*CW +: CW]);
                dy = int'(entPosY[e*CW +: CW]) - int'(obsPosY[o*CW +: CW]);
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                sx = int'(entRadX[e*RW +: RW]) + int'(obsRadX[o*RW +: RW]);
                sy = int'(entRadY[e*RW +: RW]) + int'(obsRadY[o*RW +: RW]);
                if (entValid[e] && obsValid[o] && dx < sx && dy < sy
                    && !col[e]) begin
                    col[e] = 1'b1;
                    hit[e*IW +: IW] = 2'(o);
                end
            end
        end
    endfunction

    logic            m_prev = 1'b1;
    int              m_cnt  = 0;
    logic            m_done = 1'b0;
    logic            m_ovr  = 1'b0;
    logic [NE-1:0]   m_col  = '0;
    logic [NE*IW-1:0] m_hit = '0;

    // m_cnt = cycles since the detected frame edge (0 = idle)
    always @(negedge clk) begin
        logic st;
        chk("busy", busy, 32'(m_cnt >= 1 && m_cnt <= P));
        chk("done", done, m_done);
        chk("collide", collide, m_col);
        chk("hitIndex", hitIndex, m_hit);
        chk("overrun", overrun, m_ovr);
        if (!reset_n) begin
            m_prev = 1'b1; m_cnt = 0; m_done = 1'b0;
            m_ovr = 1'b0; m_col = '0; m_hit = '0;
        end else begin
            st = frameClk && !m_prev;
            m_prev = frameClk;
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (st) m_cnt = 1;
            end else begin
                if (st) m_ovr = 1'b1;
                if (m_cnt == P) begin
                    model_results(m_col, m_hit);
                    m_done = 1'b1;
                end
                m_cnt = (m_cnt == P + 1) ? 0 : m_cnt + 1;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ent(input int e, input int x, input int y,
                           input int rx, input int ry, input logic v);
        entPosX[e*CW +: CW] = CW'(x);
        entPosY[e*CW +: CW] = CW'(y);
        entRadX[e*RW +: RW] = RW'(rx);
        entRadY[e*RW +: RW] = RW'(ry);
        entValid[e] = v;
    endtask

    task automatic set_obs(input int o, input int x, input int y,
                           input int rx, input int ry, input logic v);
        obsPosX[o*CW +: CW] = CW'(x);
        obsPosY[o*CW +: CW] = CW'(y);
        obsRadX[o*RW +: RW] = RW'(rx);
        obsRadY[o*RW +: RW] = RW'(ry);
        obsValid[o] = v;
    endtask

    task automatic run_scan(input string name);
        logic got = 1'b0;
        frameClk = 1'b0;
        tick();
        frameClk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, got, 1);
        tick();
    endtask

    // Called in the cycle the edge is detected; optional second edge
    task automatic check_window(input string name, input int edge2);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (edge2 != 0 && i == edge2 - 1) frameClk = 1'b0;
            if (edge2 != 0 && i == edge2) frameClk = 1'b1;
            @(negedge clk);
            chk({name, "_busy"}, busy, 32'(i <= P));
            chk({name, "_done"}, done, 32'(i == P + 1));
            if (edge2 != 0 && i == edge2 + 1)
                chk({name, "_ovr_set"}, overrun, 1);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        frameClk = 1'b1;
        entPosX = '0; entPosY = '0; entRadX = '0; entRadY = '0;
        obsPosX = '0; obsPosY = '0; obsRadX = '0; obsRadY = '0;
        entValid = '0; obsValid = '0;
        set_ent(0, 144, 104, 10, 10, 1'b1);
        set_ent(1, 600, 400, 10, 10, 1'b1);
        set_obs(0, 300, 300, 8, 8, 1'b1);
        set_obs(1, 50, 50, 8, 8, 1'b1);
        set_obs(2, 144, 104, 8, 20, 1'b1);
        set_obs(3, 500, 200, 8, 8, 1'b1);
        tick(3);
        reset_n = 1'b1;
        tick(3);
        chk("t1_rel_busy", busy, 0);
        chk("t1_rel_collide", collide, 0);
        chk("t1_rel_overrun", overrun, 0);
        frameClk = 1'b0;
        tick();
        frameClk = 1'b1;
        check_window("t1", 0);

        chk("t2_collide", collide, 2'b01);
        chk("t2_hit", hitIndex, 4'b0010);

        set_obs(0, 144, 104, 8, 8, 1'b1);
        set_obs(2, 800, 50, 8, 20, 1'b1);
        set_ent(0, 162, 104, 10, 10, 1'b1);
        run_scan("t3a");
        chk("t3_touch_right", collide[0], 0);
        set_ent(0, 161, 104, 10, 10, 1'b1);
        run_scan("t3b");
        chk("t3_overlap", collide, 2'b01);
        chk("t3_overlap_hit", hitIndex, 4'b0000);
        set_ent(0, 126, 104, 10, 10, 1'b1);
        run_scan("t3c");
        chk("t3_touch_left", collide[0], 0);

        set_ent(0, 300, 300, 10, 10, 1'b1);
        set_obs(1, 305, 300, 8, 8, 1'b1);
        set_obs(3, 295, 305, 8, 8, 1'b1);
        run_scan("t4a");
        chk("t4_first_hit", hitIndex, 4'b0001);
        obsValid[1] = 1'b0;
        run_scan("t4b");
        chk("t4_skip_invalid", hitIndex, 4'b0011);
        entValid[0] = 1'b0;
        run_scan("t4c");
        chk("t4_ent_invalid_col", collide, 2'b00);
        chk("t4_ent_invalid_hit", hitIndex, 4'b0000);

        frameClk = 1'b0;
        tick();
        frameClk = 1'b1;
        check_window("t5", 3);
        chk("t5_ovr_hold", overrun, 1);

        entValid[0] = 1'b1;
        obsValid[1] = 1'b1;
        run_scan("t6a");
        chk("t6_pre_collide", collide, 2'b01);
        chk("t6_ovr_sticky", overrun, 1);
        frameClk = 1'b0;
        tick();
        frameClk = 1'b1;
        tick(6);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t6_no_done", done, 0);
        end
        tick();
        chk("t6_rst_collide", collide, 2'b00);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ovr", overrun, 0);
        run_scan("t6b");
        chk("t6_fresh_collide", collide, 2'b01);
        chk("t6_fresh_hit", hitIndex, 4'b0001);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
